// File: rtl/vsc8541_smi_responder.sv
// Clause-22 SMI (MDIO) target responder.
//
// Oversamples MDC/MDIO on clk. Decodes the preamble, ST, OP, PHYAD and REGAD
// fields. Services reads and writes through a simple register port. MDIO is
// driven only during the read turnaround bit 2 and the read data phase.
//
// Ports:
//   clk          system clock; all logic runs in this domain
//   i_reset_n    asynchronous active-low reset
//   i_mdc        management clock from the station (asynchronous to clk)
//   i_mdio       MDIO pad input
//   o_mdio       MDIO drive value, meaningful when o_mdio_oe = 1
//   o_mdio_oe    MDIO tristate enable (1 = drive)
//   o_reg_addr   register address of the most recent decoded frame
//   o_wr_en      one-clk write strobe, qualified by o_reg_addr/o_wr_data
//   o_wr_data    write data
//   o_rd_en      one-clk read request strobe
//   i_rd_data    read data, captured one clk after o_rd_en
//   o_frame_err  one-clk pulse on an illegal ST or OP field
module vsc8541_smi_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic [4:0]  o_reg_addr,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_rd_en,
  input  logic [15:0] i_rd_data,
  output logic        o_frame_err
);

  localparam int unsigned     OnesW   = $clog2(PREAMBLE_LEN + 1);
  localparam logic [OnesW-1:0] OnesMax = OnesW'(PREAMBLE_LEN);

  typedef enum logic [3:0] {
    StIdle, StSt, StOp, StPhyad, StRegad, StTa, StRdata, StWdata, StSkip
  } state_e;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic                   mdc_dly_q;
  logic                   sync_mdc, sync_mdio, rise, fall;

  // Frame state
  state_e           state_q, state_d;
  logic [OnesW-1:0] ones_q, ones_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             op_hi_q, op_hi_d;
  logic             is_read_q, is_read_d;
  logic [4:0]       phyad_q, phyad_d;
  logic [4:0]       regad_q, regad_d;
  logic [15:0]      shift_q, shift_d;

  // Registered outputs
  logic        mdio_q, mdio_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        rd_en_q, rd_en_d;
  logic        frame_err_q, frame_err_d;

  assign mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], i_mdc};
  assign mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], i_mdio};
  assign sync_mdc    = mdc_sync_q[SYNC_STAGES-1];
  assign sync_mdio   = mdio_sync_q[SYNC_STAGES-1];
  assign rise        = sync_mdc & ~mdc_dly_q;
  assign fall        = ~sync_mdc & mdc_dly_q;

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    mdio_d      = mdio_q;
    mdio_oe_d   = mdio_oe_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    frame_err_d = 1'b0;

    // Read data arrives the clk after the request strobe; long before TA bit 2.
    if (rd_en_q) begin
      shift_d = i_rd_data;
    end

    if (rise) begin
      unique case (state_q)
        StIdle: begin
          if (sync_mdio) begin
            if (ones_q != OnesMax) ones_d = ones_q + 1'b1;
          end else if (ones_q == OnesMax) begin
            state_d = StSt;
            ones_d  = '0;
          end else begin
            ones_d = '0;
          end
        end
        StSt: begin
          if (sync_mdio) begin
            state_d   = StOp;
            bit_cnt_d = 5'd0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end
        StOp: begin
          if (bit_cnt_q == 5'd0) begin
            op_hi_d   = sync_mdio;
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = 5'd0;
            unique case ({op_hi_q, sync_mdio})
              2'b01: begin
                is_read_d = 1'b0;
                state_d   = StPhyad;
              end
              2'b10: begin
                is_read_d = 1'b1;
                state_d   = StPhyad;
              end
              default: begin
                frame_err_d = 1'b1;
                state_d     = StIdle;
              end
            endcase
          end
        end
        StPhyad: begin
          phyad_d = {phyad_q[3:0], sync_mdio};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            state_d   = StRegad;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StRegad: begin
          regad_d = {regad_q[3:0], sync_mdio};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d  = 5'd0;
            reg_addr_d = {regad_q[3:0], sync_mdio};
            if (phyad_q == PHY_ADDR) begin
              state_d = StTa;
              rd_en_d = is_read_q;
            end else begin
              state_d = StSkip;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StTa: begin
          // Turnaround content is not checked on writes.
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            state_d   = is_read_q ? StRdata : StWdata;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StRdata: begin
          // Counts sampled data bits; the release happens on the following fall.
          if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        StWdata: begin
          shift_d = {shift_q[14:0], sync_mdio};
          if (bit_cnt_q == 5'd15) begin
            wr_data_d = {shift_q[14:0], sync_mdio};
            wr_en_d   = 1'b1;
            bit_cnt_d = 5'd0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StSkip: begin
          // TA (2) + data (16) rises of a frame addressed to another PHY.
          if (bit_cnt_q == 5'd17) begin
            bit_cnt_d = 5'd0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d = StIdle;
          ones_d  = '0;
        end
      endcase
    end else if (fall) begin
      unique case (state_q)
        StTa: begin
          // Fall after TA bit 1 was sampled: drive the TA bit 2 zero.
          if (is_read_q && bit_cnt_q == 5'd1) begin
            mdio_oe_d = 1'b1;
            mdio_d    = 1'b0;
          end
        end
        StRdata: begin
          if (bit_cnt_q == 5'd16) begin
            mdio_oe_d = 1'b0;
            mdio_d    = 1'b1;
            bit_cnt_d = 5'd0;
            state_d   = StIdle;
          end else begin
            mdio_d  = shift_q[15];
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_dly_q   <= 1'b0;
      state_q     <= StIdle;
      ones_q      <= '0;
      bit_cnt_q   <= 5'd0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      shift_q     <= 16'd0;
      mdio_q      <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= 5'd0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 16'd0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_dly_q   <= sync_mdc;
      state_q     <= state_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      mdio_q      <= mdio_d;
      mdio_oe_q   <= mdio_oe_d;
      reg_addr_q  <= reg_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_mdio      = mdio_q;
  assign o_mdio_oe   = mdio_oe_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_en     = rd_en_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_vsc8541_smi_responder.sv
// Scoreboard bench for vsc8541_smi_responder: a station model drives MDC/MDIO
// frames, expected strobes are queued at issue time and a monitor pops and
// compares them whenever the DUT pulses o_wr_en, o_rd_en or o_frame_err.
module tb_vsc8541_smi_responder;

  localparam int Half = 8;  // clk per MDC phase

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_mdc = 1'b0;
  logic        o_mdio, o_mdio_oe;
  logic [4:0]  o_reg_addr;
  logic        o_wr_en, o_rd_en, o_frame_err;
  logic [15:0] o_wr_data;
  logic [15:0] i_rd_data = 16'h0;
  logic        st_en = 1'b0;
  logic        st_val = 1'b1;
  wire         mdio_line = o_mdio_oe ? o_mdio : (st_en ? st_val : 1'b1);

  typedef struct {
    int         kind;  // 0 write, 1 read, 2 frame error
    logic [4:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  oe_allowed = 1'b0;
  bit  oe_bad = 1'b0;

  vsc8541_smi_responder dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_mdc      (i_mdc),
    .i_mdio     (mdio_line),
    .o_mdio     (o_mdio),
    .o_mdio_oe  (o_mdio_oe),
    .o_reg_addr (o_reg_addr),
    .o_wr_en    (o_wr_en),
    .o_wr_data  (o_wr_data),
    .o_rd_en    (o_rd_en),
    .i_rd_data  (i_rd_data),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_check(input int kind, input logic [4:0] addr, input logic [15:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d addr %h data %h expected none",
               kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != 2 && e.addr !== addr) ||
          (kind == 0 && e.data !== data)) begin
        errors++;
        $display("FAIL strobe: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (o_wr_en)     mon_check(0, o_reg_addr, o_wr_data);
    if (o_rd_en)     mon_check(1, o_reg_addr, 16'h0);
    if (o_frame_err) mon_check(2, 5'h0, 16'h0);
    if (o_mdio_oe && !oe_allowed) oe_bad = 1'b1;
  end

  task automatic mdc_cycle(input logic en, input logic val, output logic s, output logic oe_s);
    st_en  = en;
    st_val = val;
    repeat (Half) @(negedge clk);
    s    = mdio_line;
    oe_s = o_mdio_oe;
    i_mdc = 1'b1;
    repeat (Half) @(negedge clk);
    i_mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic s, o;
    for (int i = n - 1; i >= 0; i--) mdc_cycle(1'b1, v[i], s, o);
  endtask

  task automatic header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] rega);
    send_bits(32'hFFFF_FFFF, pre);
    send_bits(32'h1, 2);
    send_bits({30'h0, op}, 2);
    send_bits({27'h0, phy}, 5);
    send_bits({27'h0, rega}, 5);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] rega,
                             input logic [15:0] data, input bit expect_wr);
    oe_allowed = 1'b0;
    if (expect_wr) exp_q.push_back('{kind: 0, addr: rega, data: data});
    header(pre, 2'b01, phy, rega);
    send_bits(32'h2, 2);
    send_bits({16'h0, data}, 16);
    st_en = 1'b0;
  endtask

  task automatic read_frame(input logic [4:0] phy, input logic [4:0] rega,
                            input logic [15:0] data, input bit match, input int rst_idx);
    logic s, o;
    logic [15:0] got;
    got        = 16'h0;
    i_rd_data  = data;
    oe_allowed = match;
    if (match) exp_q.push_back('{kind: 1, addr: rega, data: 16'h0});
    header(32, 2'b10, phy, rega);
    mdc_cycle(1'b0, 1'b1, s, o);
    if (match) chk("ta1_hiz", {31'h0, o}, 32'h0);
    mdc_cycle(1'b0, 1'b1, s, o);
    if (match) chk("ta2_drive", {30'h0, o, s}, 32'h2);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_idx) begin
        repeat (4) @(negedge clk);
        chk("oe_before_rst", {31'h0, o_mdio_oe}, 32'h1);
        i_reset_n = 1'b0;
        #1;
        chk("rst_release", {30'h0, o_mdio_oe, o_mdio}, 32'h1);
        oe_allowed = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
      end
      mdc_cycle(1'b0, 1'b1, s, o);
      got[15-i] = s;
    end
    if (match && rst_idx < 0) begin
      chk("rd_data", {16'h0, got}, {16'h0, data});
      repeat (6) @(negedge clk);
      chk("oe_drop", {30'h0, o_mdio_oe, o_mdio}, 32'h1);
    end
  endtask

  task automatic end_frame(input string name);
    repeat (12) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_oe"}, {31'h0, oe_bad}, 32'h0);
    oe_bad     = 1'b0;
    oe_allowed = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state",
        {6'h0, o_mdio, o_mdio_oe, o_reg_addr, o_wr_en, o_wr_data, o_rd_en, o_frame_err},
        {6'h0, 1'b1, 1'b0, 5'h0, 1'b0, 16'h0, 1'b0, 1'b0});
    i_reset_n = 1'b1;
    repeat (4) @(negedge clk);

    write_frame(32, 5'h00, 5'h1F, 16'hA5C3, 1'b1);
    end_frame("wr_1f");
    write_frame(32, 5'h00, 5'h0A, 16'h5A3C, 1'b1);
    end_frame("wr_0a");

    read_frame(5'h00, 5'h02, 16'h0007, 1'b1, -1);
    end_frame("rd_02");
    read_frame(5'h00, 5'h1F, 16'h8001, 1'b1, -1);
    end_frame("rd_1f");

    // Another PHY's address: no strobes, no drive.
    read_frame(5'h03, 5'h02, 16'h1234, 1'b0, -1);
    end_frame("rd_mismatch");
    write_frame(32, 5'h00, 5'h05, 16'h0F0F, 1'b1);
    end_frame("wr_after_mismatch");

    write_frame(31, 5'h00, 5'h1F, 16'h1111, 1'b0);
    end_frame("wr_short_pre");
    write_frame(32, 5'h00, 5'h1F, 16'h2222, 1'b1);
    end_frame("wr_full_pre");

    // Illegal opcode 11.
    exp_q.push_back('{kind: 2, addr: 5'h0, data: 16'h0});
    send_bits(32'hFFFF_FFFF, 32);
    send_bits(32'h1, 2);
    send_bits(32'h3, 2);
    st_en = 1'b0;
    end_frame("bad_op");
    write_frame(32, 5'h00, 5'h03, 16'hBEEF, 1'b1);
    end_frame("wr_after_err");

    // Reset during D8 of a read.
    read_frame(5'h00, 5'h04, 16'hC3A5, 1'b1, 7);
    end_frame("rd_reset");
    write_frame(32, 5'h00, 5'h06, 16'h1357, 1'b1);
    end_frame("wr_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
